// File: rtl/apb_wait_ram.sv
// APB slave word RAM with configurable access-phase wait states, byte strobes
// and an optional read-only upper region; all responses are registered.
module apb_wait_ram #(
    parameter int DW          = 32,
    parameter int AW          = 8,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0,
    parameter int RO_BASE     = DEPTH
) (
    input  logic            pclk,
    input  logic            presetn,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [AW-1:0]   paddr,
    input  logic [DW-1:0]   pwdata,
    input  logic [DW/8-1:0] pstrb,
    output logic [DW-1:0]   prdata,
    output logic            pready,
    output logic            pslverr
);

    localparam int          NB        = DW / 8;
    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
    localparam logic [31:0] RO_BASE_U = 32'(RO_BASE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [3:0]      cnt_r, cnt_nxt_s;
    logic [AW-1:0]   addr_r;
    logic            write_r;
    logic [DW-1:0]   wdata_r;
    logic [NB-1:0]   strb_r;
    logic            capture_s;
    logic            do_write_s;
    logic [DW-1:0]   prdata_nxt_s;
    logic            pready_nxt_s;
    logic            pslverr_nxt_s;
    logic            in_range_s;
    logic            writable_s;
    logic [IW-1:0]   idx_s;
    logic [DW-1:0]   mem_r [DEPTH];

    // Decode the captured word index against the array size and read-only base.
    assign in_range_s = (32'(addr_r) < DEPTH_U);
    assign writable_s = in_range_s && (32'(addr_r) < RO_BASE_U);
    assign idx_s      = addr_r[IW-1:0];

    // Next-state and registered-output decisions.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        prdata_nxt_s  = prdata;
        pready_nxt_s  = pready;
        pslverr_nxt_s = pslverr;
        capture_s     = 1'b0;
        do_write_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (psel && !penable) begin
                    capture_s   = 1'b1;
                    cnt_nxt_s   = 4'(WAIT_STATES);
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_nxt_s = ST_IDLE;
                end else if (penable) begin
                    if (cnt_r != 4'd0) begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end else begin
                        state_nxt_s  = ST_RESP;
                        pready_nxt_s = 1'b1;
                        if (write_r) begin
                            do_write_s    = writable_s;
                            pslverr_nxt_s = !writable_s;
                            prdata_nxt_s  = {DW{1'b0}};
                        end else begin
                            pslverr_nxt_s = !in_range_s;
                            prdata_nxt_s  = in_range_s ? mem_r[idx_s] : {DW{1'b0}};
                        end
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                pready_nxt_s  = 1'b0;
                pslverr_nxt_s = 1'b0;
                prdata_nxt_s  = {DW{1'b0}};
                state_nxt_s   = ST_IDLE;
            end
            default: begin
                pready_nxt_s  = 1'b0;
                pslverr_nxt_s = 1'b0;
                prdata_nxt_s  = {DW{1'b0}};
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            prdata  <= {DW{1'b0}};
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            prdata  <= prdata_nxt_s;
            pready  <= pready_nxt_s;
            pslverr <= pslverr_nxt_s;
        end
    end

    // Setup-phase capture; later bus changes cannot disturb the transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_r  <= {AW{1'b0}};
            write_r <= 1'b0;
            wdata_r <= {DW{1'b0}};
            strb_r  <= {NB{1'b0}};
        end else if (capture_s) begin
            addr_r  <= paddr;
            write_r <= pwrite;
            wdata_r <= pwdata;
            strb_r  <= pstrb;
        end
    end

    // Byte-lane memory write; contents deliberately survive reset.
    always_ff @(posedge pclk) begin
        for (int i = 0; i < NB; i++) begin
            if (do_write_s && strb_r[i]) begin
                mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_wait_ram.sv
// Randomised APB bench for apb_wait_ram with a word-array reference model;
// power-up contents of read-only words are learned on their first read.
module tb_apb_wait_ram;

    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int DEPTH   = 32;
    localparam int WS      = 3;
    localparam int RO_BASE = 16;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];

    apb_wait_ram #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS), .RO_BASE(RO_BASE)
    ) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer starting now (just after a rising edge).
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input bit tamper);
        int          low;
        bit          dirty;
        bit          seen;
        bit          chk_data;
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (tamper) begin
            paddr  = 8'($urandom);
            pwdata = $urandom;
            pstrb  = 4'($urandom);
        end
        low = 0;
        dirty = 1'b0;
        while (pready !== 1'b1 && low < 40) begin
            if (prdata !== 32'd0) dirty = 1'b1;
            low++;
            @(posedge pclk); #1;
        end
        seen = (pready === 1'b1);
        rd   = prdata;
        err  = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        check("pready_seen", 64'(seen), 64'd1);
        check("latency", 64'(low), 64'(1 + WS));
        check("prdata_low", 64'(dirty), 64'd0);
        check("pready_one", 64'(pready), 64'd0);
        check("prdata_clr", 64'(prdata), 64'd0);
        chk_data = 1'b1;
        exp_rd   = 32'd0;
        if (wr) begin
            exp_err = !(int'(addr) < DEPTH && int'(addr) < RO_BASE);
            if (!exp_err) begin
                for (int i = 0; i < 4; i++)
                    if (strb[i]) model_mem[addr][8*i +: 8] = data[8*i +: 8];
            end
        end else if (int'(addr) < DEPTH) begin
            exp_err = 1'b0;
            if (known[addr]) begin
                exp_rd = model_mem[addr];
            end else begin
                check("rdata_not_x", 64'(^rd === 1'bx), 64'd0);
                model_mem[addr] = rd;
                known[addr]     = 1'b1;
                chk_data        = 1'b0;
            end
        end else begin
            exp_err = 1'b1;
        end
        check("pslverr", 64'(err), 64'(exp_err));
        if (chk_data) check("prdata", 64'(rd), 64'(exp_rd));
    endtask

    initial begin
        int lowc;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'd0; pwdata = 32'd0; pstrb = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = (i < RO_BASE);
            model_mem[i] = 32'd0;
        end
        #3;
        check("rst_pready", 64'(pready), 64'd0);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        // First setup goes out on the very first edge after reset release.
        for (int i = 0; i < RO_BASE; i++) begin
            xfer(1'b1, 8'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, 1'b0);
            model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end

        xfer(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(1'b0, 8'd5, 32'd0, 4'h0, 1'b0);
        check("dir_deadbeef", 64'(model_mem[5]), 64'hDEADBEEF);
        xfer(1'b1, 8'd2, 32'h11223344, 4'hF, 1'b1);
        xfer(1'b1, 8'd2, 32'hAABBCCDD, 4'h5, 1'b1);
        xfer(1'b0, 8'd2, 32'd0, 4'h0, 1'b1);
        check("dir_merge", 64'(model_mem[2]), 64'h11BB33DD);
        xfer(1'b1, 8'd6, 32'hFFFF_FFFF, 4'h0, 1'b0);
        xfer(1'b0, 8'd6, 32'd0, 4'h0, 1'b0);
        xfer(1'b0, 8'd40, 32'd0, 4'h0, 1'b0);
        xfer(1'b1, 8'd40, 32'h0BAD_0BAD, 4'hF, 1'b0);
        xfer(1'b0, 8'd20, 32'd0, 4'h0, 1'b0);
        xfer(1'b1, 8'd20, 32'h5, 4'hF, 1'b0);
        xfer(1'b0, 8'd20, 32'd0, 4'h0, 1'b0);

        // Access phase without a setup must be ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd9; pwdata = 32'h99999999; pstrb = 4'hF;
        lowc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            if (pready !== 1'b0) lowc++;
        end
        psel = 1'b0; penable = 1'b0;
        check("no_setup_pready", 64'(lowc), 64'd0);
        xfer(1'b0, 8'd9, 32'd0, 4'h0, 1'b0);

        // Drop psel during the wait phase.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
        lowc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            if (pready !== 1'b0) lowc++;
        end
        check("abort_pready", 64'(lowc), 64'd0);
        xfer(1'b0, 8'd3, 32'd0, 4'h0, 1'b0);
        xfer(1'b1, 8'd3, 32'h3333_3333, 4'hF, 1'b0);
        xfer(1'b0, 8'd3, 32'd0, 4'h0, 1'b0);

        // Reset in the second access cycle of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; presetn = 1'b0;
        #1;
        check("rst_mid_pready", 64'(pready), 64'd0);
        check("rst_mid_prdata", 64'(prdata), 64'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); @(posedge pclk); #1; presetn = 1'b1;
        xfer(1'b0, 8'd7, 32'd0, 4'h0, 1'b0);

        // Reset during the pready cycle of a read clears outputs without an edge.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd5; pstrb = 4'h0;
        @(posedge pclk); #1; penable = 1'b1;
        lowc = 0;
        while (pready !== 1'b1 && lowc < 40) begin
            lowc++;
            @(posedge pclk); #1;
        end
        check("rst_rd_seen", 64'(pready), 64'd1);
        check("rst_rd_data", 64'(prdata), 64'(model_mem[5]));
        presetn = 1'b0;
        #1;
        check("rst_async_pready", 64'(pready), 64'd0);
        check("rst_async_prdata", 64'(prdata), 64'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1; presetn = 1'b1;

        for (int n = 0; n < 150; n++) begin
            xfer(1'($urandom), 8'($urandom_range(47, 0)), $urandom,
                 4'($urandom_range(15, 0)), 1'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) xfer(1'b0, 8'(i), 32'd0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
